// File: rtl/fpga_gpio_debounce.sv
// Per-bit GPIO input conditioner: synchroniser, prescaled stability filter, rise/fall pulses.
// Define FPGA_GPIO_DEBOUNCE_BYPASS_EN to drop the filter and forward the synchronised level directly.
module fpga_gpio_debounce #(
    parameter int                   NumInputs      = 4,
    parameter int                   SyncStages     = 2,
    parameter int                   PrescaleCycles = 1000,
    parameter int                   DebounceTicks  = 20,
    parameter logic [NumInputs-1:0] ResetValue     = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumInputs-1:0] gpio_async_i,
    output logic [NumInputs-1:0] gpio_o,
    output logic [NumInputs-1:0] rise_o,
    output logic [NumInputs-1:0] fall_o
);

    logic [NumInputs-1:0] sync_reg [SyncStages];
    logic [NumInputs-1:0] sync;
    logic [NumInputs-1:0] gpio_reg;
    logic [NumInputs-1:0] rise_reg;
    logic [NumInputs-1:0] fall_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SyncStages; s++) begin
                sync_reg[s] <= ResetValue;
            end
        end else begin
            sync_reg[0] <= gpio_async_i;
            for (int s = 1; s < SyncStages; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    assign sync   = sync_reg[SyncStages-1];
    assign gpio_o = gpio_reg;
    assign rise_o = rise_reg;
    assign fall_o = fall_reg;

`ifdef FPGA_GPIO_DEBOUNCE_BYPASS_EN

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio_reg <= ResetValue;
            rise_reg <= '0;
            fall_reg <= '0;
        end else begin
            gpio_reg <= sync;
            rise_reg <= sync & ~gpio_reg;
            fall_reg <= ~sync & gpio_reg;
        end
    end

`else

    localparam int PsWidth  = (PrescaleCycles > 1) ? $clog2(PrescaleCycles) : 1;
    localparam int CntWidth = $clog2(DebounceTicks + 1);
    localparam logic [PsWidth-1:0]  PsLast  = PsWidth'(PrescaleCycles - 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceTicks - 1);

    logic [PsWidth-1:0]   ps_reg;
    logic                 tick;
    logic [CntWidth-1:0]  cnt_reg  [NumInputs];
    logic [CntWidth-1:0]  cnt_next [NumInputs];
    logic [NumInputs-1:0] gpio_next;
    logic [NumInputs-1:0] rise_next;
    logic [NumInputs-1:0] fall_next;

    // Shared free-running prescaler; with a single-cycle period it ticks every cycle.
    assign tick = (ps_reg == PsLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ps_reg <= '0;
        end else if (tick) begin
            ps_reg <= '0;
        end else begin
            ps_reg <= ps_reg + PsWidth'(1);
        end
    end

    // Any cycle where the input agrees with the stable level restarts the count.
    always_comb begin
        gpio_next = gpio_reg;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < NumInputs; i++) begin
            cnt_next[i] = cnt_reg[i];
            if (sync[i] == gpio_reg[i]) begin
                cnt_next[i] = '0;
            end else if (tick && (cnt_reg[i] == CntLast)) begin
                gpio_next[i] = sync[i];
                cnt_next[i]  = '0;
                rise_next[i] = sync[i];
                fall_next[i] = ~sync[i];
            end else if (tick) begin
                cnt_next[i] = cnt_reg[i] + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio_reg <= ResetValue;
            rise_reg <= '0;
            fall_reg <= '0;
            for (int i = 0; i < NumInputs; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            gpio_reg <= gpio_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
            for (int i = 0; i < NumInputs; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

`endif

endmodule

// File: tb/tb_fpga_gpio_debounce.sv
// Bench for fpga_gpio_debounce: two configurations checked every cycle against a timestamp-based model.
module tb_fpga_gpio_debounce;

    localparam int         S  = 2;
    localparam logic [3:0] RV = 4'b0101;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      gpio_in = 4'b0000;
    logic [1:0][3:0] gpio_w;
    logic [1:0][3:0] rise_w;
    logic [1:0][3:0] fall_w;

    fpga_gpio_debounce #(.NumInputs(4), .SyncStages(S), .PrescaleCycles(1), .DebounceTicks(4),
                         .ResetValue(RV)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .gpio_async_i(gpio_in),
        .gpio_o(gpio_w[0]), .rise_o(rise_w[0]), .fall_o(fall_w[0]));

    fpga_gpio_debounce #(.NumInputs(4), .SyncStages(S), .PrescaleCycles(8), .DebounceTicks(3),
                         .ResetValue(RV)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .gpio_async_i(gpio_in),
        .gpio_o(gpio_w[1]), .rise_o(rise_w[1]), .fall_o(fall_w[1]));

    always #5 clk = ~clk;

    // Reference model: edge index k counts clock edges since reset release; input history gives the
    // synchronised value, and a change is accepted on the edge carrying the D-th prescaler tick
    // since the mismatch began.
    int         k;
    logic [3:0] in_hist [0:16383];
    int         mstart [2][4];
    logic [3:0] m_gpio [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    int         rise_seen [2][4];
    int         fall_seen [2][4];
    int         n_vectors = 0;
    int         n_miscompares = 0;

    function automatic int ps_of(int j);
        return (j == 0) ? 1 : 8;
    endfunction

    function automatic int db_of(int j);
        return (j == 0) ? 4 : 3;
    endfunction

    function automatic logic [3:0] sync_at(int e);
        if (e - S >= 1) return in_hist[e-S];
        return RV;
    endfunction

    // Edge e carries a tick when e is a multiple of the prescale period.
    function automatic int ticks_between(int a, int b, int p);
        return (b / p) - ((a - 1) / p);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int j = 0; j < 2; j++) begin
            m_gpio[j] = RV;
            m_rise[j] = '0;
            m_fall[j] = '0;
            for (int i = 0; i < 4; i++) mstart[j][i] = -1;
        end
    endtask

    task automatic model_edge();
        logic [3:0] s;
        k++;
        in_hist[k] = gpio_in;
        s = sync_at(k);
        for (int j = 0; j < 2; j++) begin
            m_rise[j] = '0;
            m_fall[j] = '0;
            for (int i = 0; i < 4; i++) begin
`ifdef FPGA_GPIO_DEBOUNCE_BYPASS_EN
                if (s[i] != m_gpio[j][i]) begin
                    m_gpio[j][i] = s[i];
                    if (s[i]) m_rise[j][i] = 1'b1;
                    else      m_fall[j][i] = 1'b1;
                end
`else
                if (s[i] == m_gpio[j][i]) begin
                    mstart[j][i] = -1;
                end else begin
                    if (mstart[j][i] < 0) mstart[j][i] = k;
                    if ((k % ps_of(j) == 0) &&
                        (ticks_between(mstart[j][i], k, ps_of(j)) >= db_of(j))) begin
                        m_gpio[j][i] = s[i];
                        if (s[i]) m_rise[j][i] = 1'b1;
                        else      m_fall[j][i] = 1'b1;
                        mstart[j][i] = -1;
                    end
                end
`endif
            end
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 2; j++) begin
            check((j == 0) ? "gpio_a" : "gpio_b", 32'(gpio_w[j]), 32'(m_gpio[j]));
            check((j == 0) ? "rise_a" : "rise_b", 32'(rise_w[j]), 32'(m_rise[j]));
            check((j == 0) ? "fall_a" : "fall_b", 32'(fall_w[j]), 32'(m_fall[j]));
            for (int i = 0; i < 4; i++) begin
                rise_seen[j][i] += int'(rise_w[j][i]);
                fall_seen[j][i] += int'(fall_w[j][i]);
            end
        end
    endtask

    task automatic clear_seen();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++) begin
                rise_seen[j][i] = 0;
                fall_seen[j][i] = 0;
            end
    endtask

    task automatic step(input logic [3:0] v);
        @(negedge clk);
        gpio_in = v;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        repeat (n) step(v);
    endtask

    task automatic reset_on();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    task automatic reset_release(input logic [3:0] v);
        @(negedge clk);
        rst_n = 1'b1;
        gpio_in = v;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Holds v and counts edges (from the one that first sees v) until the watched bit shows target.
    task automatic latency(input int j, input int b, input logic target, input logic [3:0] v,
                           output int n);
        n = 0;
        do begin
            step(v);
            n++;
        end while ((gpio_w[j][b] !== target) && (n < 100));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         lo;
        int         hi;
        logic [3:0] cur;
        model_reset();
        clear_seen();

        // Reset held with toggling inputs, then released with inputs equal to the reset value.
        for (int c = 0; c < 8; c++) step(4'($urandom));
        reset_release(RV);
        hold(RV, 10);
        check("rst_no_pulse", 32'(rise_seen[0][0] + fall_seen[0][0] + rise_seen[1][2]), 32'd0);

        // Clean edge on bit0 (fast config), then a falling edge on bit2 (prescaled config).
        hold(4'b0100, 40);
        clear_seen();
        latency(0, 0, 1'b1, 4'b0101, n);
`ifdef FPGA_GPIO_DEBOUNCE_BYPASS_EN
        check("lat_clean_a", 32'(n), 32'(S + 1));
`else
        check("lat_clean_a", 32'(n), 32'(S + 4));
`endif
        hold(4'b0101, 2);
        check("rise_cnt_a0", 32'(rise_seen[0][0]), 32'd1);
        hold(4'b0101, 40);

        clear_seen();
        latency(1, 2, 1'b0, 4'b0001, n);
`ifdef FPGA_GPIO_DEBOUNCE_BYPASS_EN
        lo = S + 1;
        hi = S + 1;
`else
        lo = S + 8 * (3 - 1) + 1;
        hi = S + 8 * 3;
`endif
        check("lat_ps_b_window", 32'((n >= lo) && (n <= hi)), 32'd1);
        hold(4'b0001, 40);
        check("fall_cnt_b2", 32'(fall_seen[1][2]), 32'd1);

        // Bounce on bit1: 2-cycle pulses, then a held high level.
        clear_seen();
        for (int r = 0; r < 2; r++) begin
            hold(4'b0011, 2);
            hold(4'b0001, 2);
        end
        hold(4'b0011, 10);
`ifndef FPGA_GPIO_DEBOUNCE_BYPASS_EN
        check("bounce_rise_a1", 32'(rise_seen[0][1]), 32'd1);
        check("bounce_fall_a1", 32'(fall_seen[0][1]), 32'd0);
`endif
        hold(4'b0011, 40);

        // Simultaneous: bits 0 and 3 rise while bit1 falls.
        hold(4'b0010, 40);
        n = 0;
        do begin
            step(4'b1001);
            n++;
        end while ((rise_w[0] === 4'b0000) && (n < 50));
        check("simul_timeout", 32'(n < 50), 32'd1);
        check("simul_rise_a", 32'(rise_w[0]), 32'h9);
        check("simul_fall_a", 32'(fall_w[0]), 32'h2);
        hold(4'b1001, 40);

        // Reset in the middle of a count, then a full-latency update after release.
        hold(4'b1000, 40);
        hold(4'b1011, 5);
        reset_on();
        check("midrst_gpio_a", 32'(gpio_w[0]), 32'(RV));
        hold(4'b1011, 3);
        reset_release(4'b1011);
        n = 1;
        while ((gpio_w[0][1] !== 1'b1) && (n < 100)) begin
            step(4'b1011);
            n++;
        end
`ifdef FPGA_GPIO_DEBOUNCE_BYPASS_EN
        check("midrst_lat_a", 32'(n), 32'(S + 1));
`else
        check("midrst_lat_a", 32'(n), 32'(S + 4));
`endif
        hold(4'b1011, 40);

        // Random stimulus with sparse bit flips and occasional resets.
        cur = 4'b1011;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_on();
                hold(cur, 2);
                reset_release(cur);
            end else begin
                cur = cur ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
                step(cur);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
